alu_input_sequencer: RTL and testbench
======================================

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: operand and shift width, matching the ALU width.
REQ-002 SHALL have parameter DB_CYCLES, default 16: cycles of stable-high button required for a press (debounce build only).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sw  input  N  operand switches, asynchronous to clk.
REQ-006 SHALL have port op_sw  input  4  operation-select switches.
REQ-007 SHALL have port btn  input  1  load/advance push-button, asynchronous and active-high.
REQ-008 SHALL have port a  output  N  ALU operand A.
REQ-009 SHALL have port b  output  N  ALU operand B.
REQ-010 SHALL have port data_shifts  output  N  shift data operand, equal to a.
REQ-011 SHALL have port shift_number  output  N  shift amount, equal to b.
REQ-012 SHALL have port operation  output  4  ALU operation code.
REQ-013 SHALL have port op_valid  output  1  one-cycle pulse when a complete operand set is presented.
REQ-014 SHALL have port stage  output  3  current FSM state encoding.

Function
REQ-015 SHALL pass btn through a 2-flop synchronizer; press = one-cycle pulse on a synchronized 0->1 transition, after debounce when enabled.
REQ-016 SHALL use FSM states S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_HOLD=4, with stage driven by the state register.
REQ-017 S_A + press: SHALL capture sw into a and data_shifts, then go to S_B.
REQ-018 S_B + press: SHALL capture sw into b and shift_number, then go to S_OP.
REQ-019 S_OP + press: SHALL capture op_sw into operation, then go to S_EXEC.
REQ-020 S_EXEC: SHALL assert op_valid for exactly one cycle, then go to S_HOLD unconditionally.
REQ-021 S_HOLD: SHALL hold all outputs; on press SHALL go to S_A without clearing a, b or operation.
REQ-022 A press landing in S_EXEC SHALL be dropped.
REQ-023 Without debounce, the register update SHALL occur 3 clk edges after btn rises.
REQ-024 A held btn SHALL produce exactly one press; a new press needs btn low for at least 1 synchronized cycle.
REQ-025 op_sw codes 5..15 SHALL be latched unchanged; no range checking.
REQ-026 Undefined state encodings 5..7 SHALL recover to S_A on the next edge.

Reset
REQ-027 rst high SHALL immediately force state S_A, a=b=data_shifts=shift_number=0, operation=0, op_valid=0, synchronizer and debounce counter to 0.
REQ-028 rst asserted mid-sequence SHALL discard partial captures; after release the sequence restarts at S_A.

Configuration
REQ-029 Macro ALU_SEQ_DEBOUNCE_EN defined: a press SHALL require synchronized btn high for DB_CYCLES consecutive cycles; the counter clears on any low; one press per stable-high episode.
REQ-030 Macro ALU_SEQ_DEBOUNCE_EN undefined: the debounce logic SHALL be absent, DB_CYCLES unused, press per REQ-015 only.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit operation codes (AND=0, OR=1, XOR=2, SHL=3, SHR=4) and the seq_state_t enum.
REQ-032 Synchronizer, edge detect and debounce SHALL live in sub-module btn_press, instantiated once.

Verification
REQ-033 No debounce, N=4: sw=4'b1010 press, sw=4'b0110 press, op_sw=2 press -> a=4'b1010, b=4'b0110, operation=2, single op_valid pulse, stage=4.
REQ-034 btn held high for 40 cycles in S_A -> exactly one transition, to S_B; stage=1.
REQ-035 rst pulsed while in S_OP with a=4'b1111 -> stage=0, a=0 asynchronously, op_valid stays 0.
REQ-036 Debounce build, DB_CYCLES=16: btn high for 10 cycles then low -> no state change; btn high for 20 cycles -> one advance.
REQ-037 op_sw=4'b1001 loaded -> operation=9, op_valid pulses; then press in S_HOLD -> stage=0 and a, b retained.
REQ-038 Press pulse forced to coincide with S_EXEC -> dropped; state reaches S_HOLD and stays there.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes and the input-sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;

  typedef enum logic [2:0] {
    SEQ_A    = 3'd0,
    SEQ_B    = 3'd1,
    SEQ_OP   = 3'd2,
    SEQ_EXEC = 3'd3,
    SEQ_HOLD = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_input_sequencer_if.sv
// alu_input_sequencer_if: switch/button inputs and ALU operand outputs of the
// input sequencer. slave = sequencer side, master = stimulus/consumer side.
interface alu_input_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic [3:0]   op_sw;
  logic         btn;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] data_shifts;
  logic [N-1:0] shift_number;
  logic [3:0]   operation;
  logic         op_valid;
  logic [2:0]   stage;

  modport slave (
    input  sw, op_sw, btn,
    output a, b, data_shifts, shift_number, operation, op_valid, stage
  );

  modport master (
    output sw, op_sw, btn,
    input  a, b, data_shifts, shift_number, operation, op_valid, stage
  );
endinterface

// File: rtl/alu_input_sequencer_btn_press.sv
// btn_press: synchronizes the asynchronous push-button and turns each press
// into a single-cycle pulse. With ALU_SEQ_DEBOUNCE_EN defined the pulse fires
// only after DB_CYCLES consecutive synchronized-high cycles; otherwise it
// fires on the synchronized rising edge.
module btn_press #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0] sync;
  logic       btn_s;

  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], btn};
  end

  assign btn_s = sync[1];

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt;

  // count consecutive high cycles, saturating so a long hold fires only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (!btn_s)                 cnt <= '0;
    else if (cnt != CW'(DB_CYCLES))  cnt <= cnt + 1'b1;
  end

  // fires on the DB_CYCLES-th consecutive high cycle
  assign press = btn_s && (cnt == CW'(DB_CYCLES - 1));
`else
  logic prev;

  // previous synchronized level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= btn_s;
  end

  assign press = btn_s & ~prev;
`endif

endmodule

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: steps a user through loading ALU operand A, operand B
// and the operation code with one push-button, then pulses op_valid once.
// Optional button debounce is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  alu_input_sequencer_if.slave bus
);

  localparam logic [2:0] S_A    = SEQ_A;
  localparam logic [2:0] S_B    = SEQ_B;
  localparam logic [2:0] S_OP   = SEQ_OP;
  localparam logic [2:0] S_EXEC = SEQ_EXEC;
  localparam logic [2:0] S_HOLD = SEQ_HOLD;

  logic         press;
  logic [2:0]   state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [3:0]   op_q;

  btn_press #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .press (press)
  );

  // sequencer FSM and operand capture; a press in S_EXEC is simply ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      case (state)
        S_A: if (press) begin
          a_q   <= bus.sw;
          state <= S_B;
        end
        S_B: if (press) begin
          b_q   <= bus.sw;
          state <= S_OP;
        end
        S_OP: if (press) begin
          op_q  <= bus.op_sw;
          state <= S_EXEC;
        end
        S_EXEC: state <= S_HOLD;
        S_HOLD: if (press) state <= S_A;
        default: state <= S_A;
      endcase
    end
  end

  assign bus.a            = a_q;
  assign bus.data_shifts  = a_q;
  assign bus.b            = b_q;
  assign bus.shift_number = b_q;
  assign bus.operation    = op_q;
  assign bus.op_valid     = (state == S_EXEC);
  assign bus.stage        = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboarded testbench for alu_input_sequencer.
module tb_alu_input_sequencer;
  localparam int N  = 4;
  localparam int DB = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int HOLD_MIN = DB + 2;
`else
  localparam int HOLD_MIN = 1;
`endif

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  // reference model: position in the load sequence plus latched values
  int           m_pos = 0;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  logic [3:0]   m_op = '0;

  alu_input_sequencer_if #(.N(N)) bus ();

  alu_input_sequencer #(.N(N), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_stage"}, 32'(bus.stage), 32'(m_pos));
    chk({tag, "_a"}, 32'(bus.a), 32'(m_a));
    chk({tag, "_b"}, 32'(bus.b), 32'(m_b));
    chk({tag, "_op"}, 32'(bus.operation), 32'(m_op));
    chk({tag, "_dshift"}, 32'(bus.data_shifts), 32'(m_a));
    chk({tag, "_shnum"}, 32'(bus.shift_number), 32'(m_b));
  endtask

  // advance the model by one accepted press
  task automatic model_press(input logic [N-1:0] s, input logic [3:0] o);
    exp_t e;
    case (m_pos)
      0: begin m_a = s; m_pos = 1; end
      1: begin m_b = s; m_pos = 2; end
      2: begin
        m_op = o; m_pos = 4;
        e.a = m_a; e.b = m_b; e.op = m_op;
        q.push_back(e);
      end
      default: m_pos = 0;
    endcase
  endtask

  task automatic do_press(input logic [N-1:0] s, input logic [3:0] o, input int hold, input string tag);
    bus.sw = s;
    bus.op_sw = o;
    model_press(s, o);
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (hold) @(negedge clk);
    bus.btn = 1'b0;
    repeat (4) @(negedge clk);
    chk_outputs(tag);
  endtask

  // monitor: every op_valid pulse must match the oldest expected operand set
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.op_valid) begin
        chk("opv_single_cycle", 32'(prev_v), 32'd0);
        chk("opv_stage", 32'(bus.stage), 32'd3);
        if (q.size() == 0) begin
          chk("opv_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_a", 32'(bus.a), 32'(e.a));
          chk("sb_b", 32'(bus.b), 32'(e.b));
          chk("sb_op", 32'(bus.operation), 32'(e.op));
          chk("sb_dshift", 32'(bus.data_shifts), 32'(e.a));
          chk("sb_shnum", 32'(bus.shift_number), 32'(e.b));
        end
      end
      prev_v = bus.op_valid;
    end
  end

  // watchdog
  initial begin
    #400000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic found;
    logic [N-1:0] s;
    logic [3:0] o;
    bus.sw = '0;
    bus.op_sw = '0;
    bus.btn = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs("reset");
    chk("reset_opv", 32'(bus.op_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed load: 1010, 0110, op 2
    do_press(4'b1010, 4'h0, HOLD_MIN, "ld_a");
    do_press(4'b0110, 4'h0, HOLD_MIN, "ld_b");
    do_press(4'b0000, 4'd2, HOLD_MIN, "ld_op");
    chk("directed_stage_hold", 32'(bus.stage), 32'd4);

    // press in hold returns to S_A keeping operands
    do_press(4'b0001, 4'hF, HOLD_MIN, "hold_ret");

    // out-of-range op code latched unchanged
    do_press(4'b0011, 4'h0, HOLD_MIN, "op9_a");
    do_press(4'b1100, 4'h0, HOLD_MIN, "op9_b");
    do_press(4'b0000, 4'b1001, HOLD_MIN, "op9_op");
    do_press(4'b0101, 4'h0, HOLD_MIN, "op9_ret");

`ifndef ALU_SEQ_DEBOUNCE_EN
    // latency: capture on the third rising edge after btn rises
    s = 4'b0111;
    bus.sw = s;
    @(negedge clk);
    bus.btn = 1'b1;
    @(posedge clk); #1;
    chk("lat_edge1", 32'(bus.stage), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(bus.stage), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", 32'(bus.stage), 32'd1);
    chk("lat_a", 32'(bus.a), 32'(s));
    model_press(s, 4'h0);
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (4) @(negedge clk);
    do_press(4'b0010, 4'h0, 1, "lat_b");
    do_press(4'b0000, 4'd4, 1, "lat_op");
    do_press(4'b0000, 4'h0, 1, "lat_ret");
`else
    // short glitch below the debounce threshold is ignored
    @(negedge clk);
    bus.sw = 4'b1110;
    bus.btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn = 1'b0;
    repeat (6) @(negedge clk);
    chk("db_short_stage", 32'(bus.stage), 32'd0);
    chk("db_short_a", 32'(bus.a), 32'(m_a));
`endif

    // long hold in S_A gives exactly one advance
    do_press(4'b1001, 4'h0, 40, "held40");
    chk("held40_stage", 32'(bus.stage), 32'd1);

    // reset mid-sequence while in S_OP with a = 1111
    do_press(4'b0100, 4'h0, HOLD_MIN, "pre_rst_b");
    do_press(4'b0000, 4'd1, HOLD_MIN, "pre_rst_op");
    do_press(4'b1111, 4'h0, HOLD_MIN, "pre_rst_ret");
    do_press(4'b1111, 4'h0, HOLD_MIN, "rst_a");
    do_press(4'b0011, 4'h0, HOLD_MIN, "rst_b");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    m_pos = 0; m_a = '0; m_b = '0; m_op = '0;
    chk("async_rst_stage", 32'(bus.stage), 32'd0);
    chk("async_rst_a", 32'(bus.a), 32'd0);
    chk("async_rst_opv", 32'(bus.op_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs("post_rst");

    // press forced into S_EXEC is dropped
    do_press(4'b1011, 4'h0, HOLD_MIN, "ex_a");
    do_press(4'b1101, 4'h0, HOLD_MIN, "ex_b");
    bus.op_sw = 4'd3;
    model_press('0, 4'd3);
    @(negedge clk);
    bus.btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < DB + 10; i++) begin
      @(posedge clk); #1;
      if (bus.stage == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("exec_reached", 32'(found), 32'd1);
    if (found) begin
      force dut.press = 1'b1;
      @(posedge clk); #1;
      release dut.press;
    end
    repeat (2) @(negedge clk);
    bus.btn = 1'b0;
    repeat (6) @(negedge clk);
    chk_outputs("exec_drop");

    // randomized sequences
    for (int k = 0; k < 40; k++) begin
      s = N'($urandom);
      o = 4'($urandom_range(0, 15));
      do_press(s, o, HOLD_MIN + int'($urandom_range(0, 3)), "rand");
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
